// File: rtl/apb_completer_regfile_if.sv
// APB3 bus bundle between a requester and the register-file completer.
// The master modport drives request fields; the slave modport returns the response.
interface apb_completer_regfile_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_completer_regfile.sv
// APB3 completer serving NUM_REGS word registers (word 0 = read-only ID) with
// WAIT_CYCLES wait states per transfer and PSLVERR on illegal accesses.
module apb_completer_regfile #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_CYCLES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic PCLK,
  input  logic PRESETn,
  apb_completer_regfile_if.slave apb
);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  setup;
  logic                  latch;
  logic                  commit;
  logic [ADDR_WIDTH-3:0] live_word;
  logic                  live_err;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_err;
  logic                  sel_write;
  logic [DATA_WIDTH-1:0] rd_word;

  assign setup     = apb.PSEL && !apb.PENABLE;
  assign live_word = apb.PADDR[ADDR_WIDTH-1:2];
  assign live_err  = (apb.PADDR[1:0] != 2'b00)
                  || (live_word >= (ADDR_WIDTH-2)'(NUM_REGS))
                  || (apb.PWRITE && (live_word == '0));

  // In IDLE a zero-wait transfer enters READY straight from the setup edge,
  // so the read mux must look at the live bus rather than the latched copy.
  assign sel_idx   = (state_q == S_IDLE) ? live_word[IDX_W-1:0] : idx_q;
  assign sel_err   = (state_q == S_IDLE) ? live_err : err_q;
  assign sel_write = (state_q == S_IDLE) ? apb.PWRITE : write_q;

  always_comb begin
    rd_word = '0;
    if (!sel_err && !sel_write) begin
      rd_word = (sel_idx == '0) ? ID_VALUE : regs_q[sel_idx];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    latch     = 1'b0;
    commit    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (setup) begin
          latch = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d   = S_READY;
            pready_d  = 1'b1;
            pslverr_d = sel_err;
            prdata_d  = rd_word;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (!apb.PSEL) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d   = S_READY;
          cnt_d     = '0;
          pready_d  = 1'b1;
          pslverr_d = sel_err;
          prdata_d  = rd_word;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_READY: begin
        state_d = S_IDLE;
        // A dropped PSEL here is an abort: the write is discarded.
        commit  = apb.PSEL && apb.PENABLE && write_q && !err_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      if (latch) begin
        idx_q   <= live_word[IDX_W-1:0];
        write_q <= apb.PWRITE;
        err_q   <= live_err;
        wdata_q <= apb.PWDATA;
      end
    end
  end

  // Word 0 is never written: any write to it is flagged as an error.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[idx_q] <= wdata_q;
    end
  end

  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign apb.PRDATA  = prdata_q;
endmodule

// File: tb/tb_apb_completer_regfile.sv
// Drives three completers (0, 1 and 15 wait states) and compares every
// transfer against an array-based model of the register map.
module tb_apb_completer_regfile;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NREG = 16;
  localparam logic [31:0] ID   = 32'hA9B0_0001;
  localparam int          WC [3] = '{0, 1, 15};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        psel_r [3];
  logic        penable_r [3];
  logic        pwrite_r [3];
  logic [31:0] paddr_r [3];
  logic [31:0] pwdata_r [3];
  logic [31:0] prdata_w [3];
  logic        pready_w [3];
  logic        pslverr_w [3];

  apb_completer_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  apb_completer_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
  apb_completer_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

  assign bus0.PSEL = psel_r[0];    assign bus0.PENABLE = penable_r[0];
  assign bus0.PWRITE = pwrite_r[0]; assign bus0.PADDR = paddr_r[0];
  assign bus0.PWDATA = pwdata_r[0];
  assign prdata_w[0] = bus0.PRDATA; assign pready_w[0] = bus0.PREADY;
  assign pslverr_w[0] = bus0.PSLVERR;

  assign bus1.PSEL = psel_r[1];    assign bus1.PENABLE = penable_r[1];
  assign bus1.PWRITE = pwrite_r[1]; assign bus1.PADDR = paddr_r[1];
  assign bus1.PWDATA = pwdata_r[1];
  assign prdata_w[1] = bus1.PRDATA; assign pready_w[1] = bus1.PREADY;
  assign pslverr_w[1] = bus1.PSLVERR;

  assign bus2.PSEL = psel_r[2];    assign bus2.PENABLE = penable_r[2];
  assign bus2.PWRITE = pwrite_r[2]; assign bus2.PADDR = paddr_r[2];
  assign bus2.PWDATA = pwdata_r[2];
  assign prdata_w[2] = bus2.PRDATA; assign pready_w[2] = bus2.PREADY;
  assign pslverr_w[2] = bus2.PSLVERR;

  apb_completer_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NREG),
                          .WAIT_CYCLES(0), .ID_VALUE(ID))
    dut0 (.PCLK(clk), .PRESETn(rst_n), .apb(bus0));
  apb_completer_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NREG),
                          .WAIT_CYCLES(1), .ID_VALUE(ID))
    dut1 (.PCLK(clk), .PRESETn(rst_n), .apb(bus1));
  apb_completer_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NREG),
                          .WAIT_CYCLES(15), .ID_VALUE(ID))
    dut2 (.PCLK(clk), .PRESETn(rst_n), .apb(bus2));

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference register map, one bank per completer.
  logic [31:0] model [3][NREG];

  function automatic void model_clear();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NREG; i++) model[k][i] = '0;
  endfunction

  function automatic void model_exp(input int k, input bit wr, input logic [31:0] addr,
                                    output logic [31:0] rd, output bit err);
    int idx;
    idx = int'(addr >> 2);
    err = (addr[1:0] != 2'b00) || (idx >= NREG) || (wr && idx == 0);
    rd  = '0;
    if (!err && !wr) rd = (idx == 0) ? ID : model[k][idx];
  endfunction

  function automatic void model_commit(input int k, input bit wr, input logic [31:0] addr,
                                       input logic [31:0] wdata);
    logic [31:0] rd;
    bit err;
    model_exp(k, wr, addr, rd, err);
    if (wr && !err) model[k][int'(addr >> 2)] = wdata;
  endfunction

  // Called just after a rising edge; returns just after the completion edge.
  task automatic xfer(input int k, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rd, output bit err, output int waits, output int cycles);
    int c0;
    c0 = cyc;
    psel_r[k] = 1'b1; penable_r[k] = 1'b0; pwrite_r[k] = wr;
    paddr_r[k] = addr; pwdata_r[k] = wdata;
    @(posedge clk); #1;
    penable_r[k] = 1'b1;
    paddr_r[k] = $urandom; pwdata_r[k] = $urandom;
    waits = 0;
    while (pready_w[k] !== 1'b1 && waits < 40) begin
      check($sformatf("pslverr_low_in_wait k%0d", k), 32'(pslverr_w[k]), 32'd0);
      waits++;
      @(posedge clk); #1;
    end
    rd  = prdata_w[k];
    err = pslverr_w[k];
    @(posedge clk); #1;
    psel_r[k] = 1'b0; penable_r[k] = 1'b0;
    cycles = cyc - c0;
    check($sformatf("pready_one_cycle k%0d", k), 32'(pready_w[k]), 32'd0);
  endtask

  task automatic do_check(input int k, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] exp_rd, rd;
    bit exp_err, err;
    int waits, cycles;
    model_exp(k, wr, addr, exp_rd, exp_err);
    xfer(k, wr, addr, wdata, rd, err, waits, cycles);
    check($sformatf("prdata k%0d wr%0d a%h", k, wr, addr), rd, exp_rd);
    check($sformatf("pslverr k%0d wr%0d a%h", k, wr, addr), 32'(err), 32'(exp_err));
    check($sformatf("waits k%0d a%h", k, addr), 32'(waits), 32'(WC[k]));
    check($sformatf("cycles k%0d a%h", k, addr), 32'(cycles), 32'(2 + WC[k]));
    model_commit(k, wr, addr, wdata);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] rd;
    bit          err;
    int          waits, cycles, c0;

    for (int k = 0; k < 3; k++) begin
      psel_r[k] = 1'b0; penable_r[k] = 1'b0; pwrite_r[k] = 1'b0;
      paddr_r[k] = '0; pwdata_r[k] = '0;
    end
    model_clear();

    vecs[0] = '{1'b1, 32'h8,  32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 32'h8,  32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h40, 32'h1111_0001, 32'h0,         1'b1};
    vecs[3] = '{1'b1, 32'h6,  32'h2222_0002, 32'h0,         1'b1};
    vecs[4] = '{1'b1, 32'h0,  32'h3333_0003, 32'h0,         1'b1};
    vecs[5] = '{1'b0, 32'h0,  32'h0,         32'hA9B0_0001, 1'b0};
    vecs[6] = '{1'b0, 32'h40, 32'h0,         32'h0,         1'b1};
    vecs[7] = '{1'b0, 32'h8,  32'h0,         32'hDEAD_BEEF, 1'b0};

    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset pready k%0d", k), 32'(pready_w[k]), 32'd0);
      check($sformatf("reset pslverr k%0d", k), 32'(pslverr_w[k]), 32'd0);
      check($sformatf("reset prdata k%0d", k), prdata_w[k], 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset in the middle of live transfers.
    do_check(1, 1'b1, 32'h4, 32'h1111_2222);
    do_check(2, 1'b1, 32'h4, 32'h3333_4444);
    psel_r[1] = 1'b1; penable_r[1] = 1'b0; pwrite_r[1] = 1'b0; paddr_r[1] = 32'h0;
    psel_r[2] = 1'b1; penable_r[2] = 1'b0; pwrite_r[2] = 1'b1; paddr_r[2] = 32'h8;
    pwdata_r[2] = 32'h5555_6666;
    @(posedge clk); #1;
    penable_r[1] = 1'b1; penable_r[2] = 1'b1;
    @(posedge clk); #1;
    check("pre_reset pready k1", 32'(pready_w[1]), 32'd1);
    check("pre_reset prdata k1", prdata_w[1], ID);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset pready k1", 32'(pready_w[1]), 32'd0);
    check("async_reset prdata k1", prdata_w[1], 32'd0);
    check("async_reset pslverr k1", 32'(pslverr_w[1]), 32'd0);
    check("async_reset pready k2", 32'(pready_w[2]), 32'd0);
    psel_r[1] = 1'b0; penable_r[1] = 1'b0; psel_r[2] = 1'b0; penable_r[2] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    model_clear();
    for (int i = 1; i < NREG; i++) begin
      do_check(1, 1'b0, 32'(i * 4), 32'h0);
      do_check(2, 1'b0, 32'(i * 4), 32'h0);
    end

    // Write/read and error vectors on the one-wait completer.
    for (int v = 0; v < 8; v++) begin
      xfer(1, vecs[v].wr, vecs[v].addr, vecs[v].wdata, rd, err, waits, cycles);
      check($sformatf("vec%0d prdata", v), rd, vecs[v].exp_rd);
      check($sformatf("vec%0d pslverr", v), 32'(err), 32'(vecs[v].exp_err));
      check($sformatf("vec%0d waits", v), 32'(waits), 32'd1);
      check($sformatf("vec%0d cycles", v), 32'(cycles), 32'd3);
      model_commit(1, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
    end

    // Zero-wait back-to-back writes, then readback.
    c0 = cyc;
    for (int i = 0; i < 4; i++) do_check(0, 1'b1, 32'(4 + 4 * i), 32'hC0DE_0000 + 32'(i));
    check("b2b total cycles", 32'(cyc - c0), 32'd8);
    for (int i = 0; i < 4; i++) do_check(0, 1'b0, 32'(4 + 4 * i), 32'h0);

    // Abort during WAIT.
    psel_r[1] = 1'b1; penable_r[1] = 1'b0; pwrite_r[1] = 1'b1;
    paddr_r[1] = 32'hC; pwdata_r[1] = 32'h1;
    @(posedge clk); #1;
    penable_r[1] = 1'b1;
    check("abort_wait pready", 32'(pready_w[1]), 32'd0);
    psel_r[1] = 1'b0; penable_r[1] = 1'b0;
    @(posedge clk); #1;
    check("abort_wait idle pready", 32'(pready_w[1]), 32'd0);
    do_check(1, 1'b0, 32'hC, 32'h0);

    // Abort in READY: PSEL drops before the completion edge.
    psel_r[1] = 1'b1; penable_r[1] = 1'b0; pwrite_r[1] = 1'b1;
    paddr_r[1] = 32'h10; pwdata_r[1] = 32'h5;
    @(posedge clk); #1 penable_r[1] = 1'b1;
    @(posedge clk); #1;
    check("abort_ready pready", 32'(pready_w[1]), 32'd1);
    psel_r[1] = 1'b0; penable_r[1] = 1'b0;
    @(posedge clk); #1;
    check("abort_ready dropped pready", 32'(pready_w[1]), 32'd0);
    do_check(1, 1'b0, 32'h10, 32'h0);

    // Maximum wait count.
    do_check(2, 1'b1, 32'h3C, 32'hFEED_F00D);
    do_check(2, 1'b0, 32'h3C, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 150; n++) begin
      int k, idx, low;
      bit wr;
      k   = $urandom_range(0, 2);
      idx = $urandom_range(0, 17);
      low = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      wr  = 1'($urandom_range(0, 1));
      do_check(k, wr, 32'(idx * 4 + low), $urandom);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
